// File: rtl/uart_transceiver.sv
// uart_transceiver: 16x-oversampled UART receiver and transmitter sharing one free-running baud tick
module uart_transceiver #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int BAUD_DIV = 326,
  parameter int SB_TICK  = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic [NB_DATA-1:0] i_tx,
  input  logic               i_tx_start,
  output logic [NB_DATA-1:0] o_rx,
  output logic               o_rx_done_tick,
  output logic               o_tx,
  output logic               o_tx_done_tick
);
  localparam int NB_T = $clog2(BAUD_DIV + 1);
  localparam int NB_S = $clog2((SB_TICK > 16 ? SB_TICK : 16) + 1 + 0 * NB_OP);
  localparam int NB_N = $clog2(NB_DATA + 1);
  localparam logic [NB_T-1:0] T_LAST = NB_T'(BAUD_DIV - 1);
  localparam logic [NB_S-1:0] S_MID  = NB_S'(7);
  localparam logic [NB_S-1:0] S_BIT  = NB_S'(15);
  localparam logic [NB_S-1:0] S_STOP = NB_S'(SB_TICK - 1);
  localparam logic [NB_N-1:0] N_LAST = NB_N'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic               tick;
  logic [NB_T-1:0]    tick_cnt_q, tick_cnt_d;
  state_t             rx_state_q, rx_state_d;
  logic [NB_S-1:0]    rx_s_q, rx_s_d;
  logic [NB_N-1:0]    rx_n_q, rx_n_d;
  logic [NB_DATA-1:0] rx_b_q, rx_b_d;
  logic [NB_DATA-1:0] rx_q, rx_d;
  logic               rx_done_q, rx_done_d;
  state_t             tx_state_q, tx_state_d;
  logic [NB_S-1:0]    tx_s_q, tx_s_d;
  logic [NB_N-1:0]    tx_n_q, tx_n_d;
  logic [NB_DATA-1:0] tx_b_q, tx_b_d;
  logic               tx_q, tx_d;
  logic               tx_done_q, tx_done_d;

  assign o_rx           = rx_q;
  assign o_rx_done_tick = rx_done_q;
  assign o_tx           = tx_q;
  assign o_tx_done_tick = tx_done_q;

  // baud tick: wraps at BAUD_DIV-1 and pulses on the last count
  always_comb begin
    tick       = tick_cnt_q == T_LAST;
    tick_cnt_d = tick ? '0 : tick_cnt_q + NB_T'(1);
  end

  // receiver: validate start at mid-bit, then sample each data bit at its centre
  always_comb begin
    rx_state_d = rx_state_q;
    rx_s_d     = rx_s_q;
    rx_n_d     = rx_n_q;
    rx_b_d     = rx_b_q;
    rx_d       = rx_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      IDLE: if (!i_rx) begin
        rx_state_d = START;
        rx_s_d     = '0;
      end
      START: if (tick) begin
        if (rx_s_q == S_MID) begin
          rx_state_d = i_rx ? IDLE : DATA;
          rx_s_d     = '0;
          rx_n_d     = '0;
        end else rx_s_d = rx_s_q + NB_S'(1);
      end
      DATA: if (tick) begin
        if (rx_s_q == S_BIT) begin
          rx_s_d = '0;
          rx_b_d = NB_DATA'({i_rx, rx_b_q} >> 1);
          if (rx_n_q == N_LAST) rx_state_d = STOP;
          else rx_n_d = rx_n_q + NB_N'(1);
        end else rx_s_d = rx_s_q + NB_S'(1);
      end
      STOP: if (tick) begin
        if (rx_s_q == S_STOP) begin
          rx_state_d = IDLE;
          rx_d       = rx_b_q;
          rx_done_d  = 1'b1;
        end else rx_s_d = rx_s_q + NB_S'(1);
      end
      default: rx_state_d = IDLE;
    endcase
  end

  // transmitter: line level follows the next state so o_tx is a clean register output
  always_comb begin
    tx_state_d = tx_state_q;
    tx_s_d     = tx_s_q;
    tx_n_d     = tx_n_q;
    tx_b_d     = tx_b_q;
    tx_done_d  = 1'b0;
    case (tx_state_q)
      IDLE: if (i_tx_start) begin
        tx_state_d = START;
        tx_s_d     = '0;
        tx_b_d     = i_tx;
      end
      START: if (tick) begin
        if (tx_s_q == S_BIT) begin
          tx_state_d = DATA;
          tx_s_d     = '0;
          tx_n_d     = '0;
        end else tx_s_d = tx_s_q + NB_S'(1);
      end
      DATA: if (tick) begin
        if (tx_s_q == S_BIT) begin
          tx_s_d = '0;
          tx_b_d = tx_b_q >> 1;
          if (tx_n_q == N_LAST) tx_state_d = STOP;
          else tx_n_d = tx_n_q + NB_N'(1);
        end else tx_s_d = tx_s_q + NB_S'(1);
      end
      STOP: if (tick) begin
        if (tx_s_q == S_STOP) begin
          tx_state_d = IDLE;
          tx_done_d  = 1'b1;
        end else tx_s_d = tx_s_q + NB_S'(1);
      end
      default: tx_state_d = IDLE;
    endcase
    tx_d = tx_state_d == START ? 1'b0 : tx_state_d == DATA ? tx_b_d[0] : 1'b1;
  end

  // state registers; reset aborts any frame in flight and idles the line high
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
      rx_state_q <= IDLE;
      rx_s_q     <= '0;
      rx_n_q     <= '0;
      rx_b_q     <= '0;
      rx_q       <= '0;
      rx_done_q  <= 1'b0;
      tx_state_q <= IDLE;
      tx_s_q     <= '0;
      tx_n_q     <= '0;
      tx_b_q     <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rx_state_q <= rx_state_d;
      rx_s_q     <= rx_s_d;
      rx_n_q     <= rx_n_d;
      rx_b_q     <= rx_b_d;
      rx_q       <= rx_d;
      rx_done_q  <= rx_done_d;
      tx_state_q <= tx_state_d;
      tx_s_q     <= tx_s_d;
      tx_n_q     <= tx_n_d;
      tx_b_q     <= tx_b_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end
endmodule

// File: tb/tb_uart_transceiver.sv
// tb_uart_transceiver: directed scoreboard bench for uart_transceiver at a reduced baud divider
module tb_uart_transceiver;
  localparam int TICK = 4;
  localparam int BIT  = 16 * TICK;
  localparam int FR   = 11 * BIT;

  logic       clk = 1'b0;
  logic       rst;
  logic       loop;
  logic       rx_drv;
  logic       rx_line;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] o_rx;
  logic       o_rx_done_tick;
  logic       o_tx;
  logic       o_tx_done_tick;

  int         checks = 0;
  int         errors = 0;
  int         rx_done_cnt = 0;
  int         tx_done_cnt = 0;
  int         base;
  logic       exp_bits[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_seen[$];
  logic       tx_wave[FR];

  always #5 clk = ~clk;

  assign rx_line = loop ? o_tx : rx_drv;

  uart_transceiver #(.NB_DATA(8), .NB_OP(6), .BAUD_DIV(TICK), .SB_TICK(16)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_rx          (rx_line),
    .i_tx          (tx_data),
    .i_tx_start    (tx_start),
    .o_rx          (o_rx),
    .o_rx_done_tick(o_rx_done_tick),
    .o_tx          (o_tx),
    .o_tx_done_tick(o_tx_done_tick)
  );

  always @(posedge clk) begin
    if (o_tx_done_tick) tx_done_cnt <= tx_done_cnt + 1;
    if (o_rx_done_tick) begin
      rx_done_cnt <= rx_done_cnt + 1;
      rx_seen.push_back(o_rx);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit track);
    tx_data  = b;
    tx_start = 1'b1;
    if (track && loop) exp_rx.push_back(b);
    if (track && !loop) begin
      exp_bits.push_back(1'b0);
      for (int k = 0; k < 8; k++) exp_bits.push_back(b[k]);
      exp_bits.push_back(1'b1);
    end
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_fall();
    for (int i = 0; i < 4 * BIT && o_tx !== 1'b0; i++) @(negedge clk);
    check("tx_start_seen", o_tx, 0);
  endtask

  task automatic capture(input logic [7:0] inj, input bit pulse);
    for (int i = 0; i < FR; i++) begin
      tx_wave[i] = o_tx;
      if (i == 2 * BIT) begin
        tx_data  = inj;
        tx_start = pulse;
      end
      if (i == 2 * BIT + 1) tx_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic analyze();
    int j;
    int run;
    for (int k = 0; k < 10; k++)
      check("tx_bit", tx_wave[BIT / 2 + k * BIT], exp_bits.size() ? exp_bits.pop_front() : 1'bx);
    j = 0;
    while (j < FR && tx_wave[j] == 1'b0) j++;
    check("start_len_ok", (j >= BIT - TICK + 1 && j <= BIT), 1);
    run = 0;
    while (j < FR && tx_wave[j] == 1'b1) begin
      run++;
      j++;
    end
    check("bit_len", run, BIT);
    check("tx_tail_idle", tx_wave[FR-1], 1);
  endtask

  task automatic watch_idle(input int n, input string tag);
    bit low = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_tx !== 1'b1) low = 1'b1;
    end
    check(tag, low, 0);
  endtask

  initial begin
    rst      = 1'b1;
    loop     = 1'b0;
    rx_drv   = 1'b1;
    tx_data  = 8'h00;
    tx_start = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_o_tx", o_tx, 1);
    check("rst_o_rx", o_rx, 8'h00);
    check("rst_rx_done", o_rx_done_tick, 0);
    check("rst_tx_done", o_tx_done_tick, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h01, 1'b1);
    wait_fall();
    base = tx_done_cnt;
    capture(8'hFF, 1'b0);
    analyze();
    check("tx_done_once", tx_done_cnt - base, 1);
    repeat (BIT) @(negedge clk);
    send(8'h01, 1'b1);
    wait_fall();
    base = tx_done_cnt;
    capture(8'h07, 1'b1);
    analyze();
    check("busy_done_once", tx_done_cnt - base, 1);
    watch_idle(2 * BIT, "busy_no_second_frame");
    check("no_rx_yet", rx_done_cnt, 0);
    loop = 1'b1;
    repeat (BIT) @(negedge clk);
    send(8'h03, 1'b1);
    for (int i = 0; i < 12 * BIT && o_tx_done_tick !== 1'b1; i++) @(negedge clk);
    check("lb_tx_done_seen", o_tx_done_tick, 1);
    send(8'hA5, 1'b1);
    check("b2b_start_now", o_tx, 0);
    for (int i = 0; i < 14 * BIT && rx_done_cnt < 2; i++) @(negedge clk);
    check("lb_rx_frames", rx_done_cnt, 2);
    while (exp_rx.size() != 0) check("lb_rx_byte", rx_seen.size() ? rx_seen.pop_front() : 8'hxx, exp_rx.pop_front());
    repeat (2 * BIT) @(negedge clk);
    check("lb_o_rx_hold", o_rx, 8'hA5);
    loop = 1'b0;
    repeat (BIT) @(negedge clk);
    base = rx_done_cnt;
    rx_drv = 1'b0;
    repeat (3 * TICK) @(negedge clk);
    rx_drv = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("glitch_no_done", rx_done_cnt - base, 0);
    check("glitch_o_rx", o_rx, 8'hA5);
    send(8'h00, 1'b0);
    wait_fall();
    repeat (3 * BIT) @(negedge clk);
    check("mid_tx_low", o_tx, 0);
    base = tx_done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_o_tx", o_tx, 1);
    check("mid_rst_o_rx", o_rx, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch_idle(12 * BIT, "post_rst_idle");
    check("mid_rst_no_done", tx_done_cnt - base, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 Parameter NB_DATA, default 8: data bits per frame, and the width of i_tx and o_rx.
REQ-002 Parameter NB_OP, default 6: interface-compatibility parameter with no functional effect.
REQ-003 Parameter BAUD_DIV, default 326: system clocks per oversampling tick (100 MHz clock, 19200 baud, 16x oversampling).
REQ-004 Parameter SB_TICK, default 16: oversampling ticks per stop bit.
REQ-005 Port i_clock, input, 1 bit: single system clock; all logic is rising-edge.
REQ-006 Port i_reset, input, 1 bit: reset; synchronous, active-high.
REQ-007 Port i_rx, input, 1 bit: serial receive line, idle high.
REQ-008 Port i_tx, input, NB_DATA bits: byte to transmit.
REQ-009 Port i_tx_start, input, 1 bit: transmit request, sampled every clock.
REQ-010 Port o_rx, output, NB_DATA bits: last received byte.
REQ-011 Port o_rx_done_tick, output, 1 bit: one-clock pulse when a received byte is valid.
REQ-012 Port o_tx, output, 1 bit: serial transmit line, idle high.
REQ-013 Port o_tx_done_tick, output, 1 bit: one-clock pulse at the end of a transmitted frame.

Function
REQ-014 Tick generator SHALL count 0..BAUD_DIV-1 and wrap, asserting a one-clock tick when the count equals BAUD_DIV-1; it is shared by RX and TX and free-running.
REQ-015 Frame format SHALL be 1 start bit (0), NB_DATA data bits LSB first, 1 stop bit (1), with no parity.
REQ-016 RX SHALL implement a state machine with states IDLE, START, DATA, STOP.
REQ-017 RX IDLE: when i_rx is sampled low, go to START and clear the tick counter.
REQ-018 RX START: count ticks; at tick count 7 (mid start bit) re-check i_rx. If still low, go to DATA; if high (glitch), return to IDLE with no output.
REQ-019 RX DATA: every 16 ticks, sample i_rx into a shift register (new bit at MSB, shift right). After NB_DATA samples, go to STOP.
REQ-020 RX STOP: after SB_TICK ticks, load the shift register into o_rx, pulse o_rx_done_tick for exactly 1 clock, and go to IDLE.
REQ-021 RX framing: the stop-bit level is not checked and the byte is delivered regardless; there is no error output.
REQ-022 o_rx SHALL hold its value until the next completed frame.
REQ-023 TX SHALL implement a state machine with states IDLE, START, DATA, STOP.
REQ-024 TX IDLE: o_tx=1. When i_tx_start=1, latch i_tx, go to START, and clear the tick counter.
REQ-025 TX START: drive o_tx=0 for 16 ticks.
REQ-026 TX DATA: drive the latched data LSB first, each bit for 16 ticks.
REQ-027 TX STOP: drive o_tx=1 for SB_TICK ticks, then pulse o_tx_done_tick for 1 clock and go to IDLE.
REQ-028 i_tx_start while TX is not in IDLE SHALL be ignored; changes to i_tx after the latch do not affect the frame in flight.
REQ-029 A new i_tx_start in the clock after o_tx_done_tick SHALL start a new frame with no extra idle time required.
REQ-030 RX and TX SHALL operate fully independently; simultaneous receive and transmit are supported.
REQ-031 The o_tx output SHALL be registered and glitch-free.

Reset
REQ-032 While i_reset=1 at a clock edge: both FSMs go to IDLE, the tick generator and all counters go to 0, o_tx=1, o_rx=0, o_rx_done_tick=0, o_tx_done_tick=0.
REQ-033 Reset mid-frame SHALL abort the frame silently, with no done pulse.
REQ-034 After reset release, RX SHALL wait for a fresh falling start edge.

Verification
REQ-035 Reset check: hold i_reset for 10 clocks -> o_tx=1, o_rx=0x00, both done ticks 0.
REQ-036 TX frame: i_tx=0x01, pulse i_tx_start for 1 clock -> o_tx shows 0,1,0,0,0,0,0,0,0,1, each bit 5216 clocks long; o_tx_done_tick pulses once, about 52160 clocks after start.
REQ-037 Loopback: o_tx wired to i_rx, send 0x03, then 0xA5 after done -> o_rx_done_tick pulses twice; o_rx=0x03, then 0xA5.
REQ-038 Glitch: drive i_rx low for 3 ticks, then high -> no o_rx_done_tick, and o_rx is unchanged.
REQ-039 Busy: pulse i_tx_start with 0x07 during a 0x01 frame -> only the 0x01 frame is sent, with one done tick.
REQ-040 Reset mid-TX: assert i_reset during DATA -> o_tx=1 the next clock, with no o_tx_done_tick.
